adpcm_b_requester: RTL and testbench

Chip-side model of the YM2610 ADPCM-B sample-memory interface, the opposite end of the PMPX/nybble-bus protocol served by the board's ADPCM-B memory responder.
- Accepts a 24-bit fetch request and signals the address strobe with PMPX.
- Presents the address nybbles on the 4-bit bus in response to the responder's mux selects.
- Captures the returned PCM byte.
- Used for on-board loopback self-test and simulation in place of a real YM2610.

---
 rtl/adpcm_b_requester.sv | 165 ++++++++++++++++
 tb/tb_adpcm_b_requester.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adpcm_b_requester.sv
// YM2610-side ADPCM-B fetch requester: PMPX address strobe, nybble-lane address mux, byte capture.
// Optional protocol checker enabled by defining ADPCM_B_REQUESTER_CHECK_EN.
module adpcm_b_requester #(
    parameter int unsigned PMPX_HIGH_CYCLES = 4,
    parameter int unsigned MUX_LATENCY      = 2,
    parameter int unsigned TIMEOUT_CYCLES   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    output logic        req_ready,
    output logic        pmpx,
    output logic        pmpx_rose,
    output logic        pmpx_fell,
    input  logic [2:0]  mux_sel,
    input  logic        mux_oe_n,
    output logic [3:0]  ym_io,
    input  logic [3:0]  pcm_nybble,
    input  logic        ym_io_en,
    input  logic        pcm_load,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        proto_error
);

    typedef enum logic [1:0] {StIdle, StPhaseA, StPhaseB, StResp} state_e;

    state_e      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [3:0]  phase_cnt_q, phase_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        first_q, first_d;
    logic [3:0]  lo_q, lo_d;
    logic [3:0]  hi_q, hi_d;
    logic        timed_out_q, timed_out_d;
    logic [3:0]  pipe_q [MUX_LATENCY];
    logic [3:0]  pipe_d [MUX_LATENCY];
    logic [3:0]  lane;

    logic in_a, in_b;
    assign in_a = (state_q == StPhaseA);
    assign in_b = (state_q == StPhaseB);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        phase_cnt_d = phase_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        first_d     = 1'b0;
        lo_d        = lo_q;
        hi_d        = hi_q;
        timed_out_d = timed_out_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d     = StPhaseA;
                    addr_d      = req_addr;
                    phase_cnt_d = 4'd0;
                    tmo_cnt_d   = 8'd0;
                    first_d     = 1'b1;
                    lo_d        = 4'd0;
                    hi_d        = 4'd0;
                    timed_out_d = 1'b0;
                end
            end
            StPhaseA: begin
                tmo_cnt_d = tmo_cnt_q + 8'd1;
                if (phase_cnt_q == 4'(PMPX_HIGH_CYCLES - 1)) begin
                    state_d = StPhaseB;
                    first_d = 1'b1;
                end else begin
                    phase_cnt_d = phase_cnt_q + 4'd1;
                end
            end
            StPhaseB: begin
                tmo_cnt_d = tmo_cnt_q + 8'd1;
                if (ym_io_en && mux_sel == 3'b101) lo_d = pcm_nybble;
                // Data capture takes priority over a coincident timeout expiry.
                if (ym_io_en && pcm_load) begin
                    hi_d    = pcm_nybble;
                    state_d = StResp;
                end else if (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = StResp;
                    timed_out_d = 1'b1;
                    lo_d        = 4'd0;
                    hi_d        = 4'd0;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        lane = 4'd0;
        if (!mux_oe_n && (in_a || in_b)) begin
            case (mux_sel)
                3'b010:  lane = in_b ? addr_q[15:12] : addr_q[3:0];
                3'b110:  lane = in_b ? addr_q[19:16] : addr_q[7:4];
                3'b011:  lane = in_b ? addr_q[23:20] : addr_q[11:8];
                default: lane = 4'd0;
            endcase
        end
        pipe_d[0] = lane;
        for (int i = 1; i < int'(MUX_LATENCY); i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= 24'd0;
            phase_cnt_q <= 4'd0;
            tmo_cnt_q   <= 8'd0;
            first_q     <= 1'b0;
            lo_q        <= 4'd0;
            hi_q        <= 4'd0;
            timed_out_q <= 1'b0;
            for (int i = 0; i < int'(MUX_LATENCY); i++) pipe_q[i] <= 4'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            phase_cnt_q <= phase_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            first_q     <= first_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            timed_out_q <= timed_out_d;
            for (int i = 0; i < int'(MUX_LATENCY); i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign busy        = !req_ready;
    assign pmpx        = in_a;
    assign pmpx_rose   = in_a && first_q;
    assign pmpx_fell   = in_b && first_q;
    assign rsp_valid   = (state_q == StResp);
    assign rsp_timeout = rsp_valid && timed_out_q;
    assign rsp_data    = rsp_valid ? {hi_q, lo_q} : 8'h00;
    assign ym_io       = pipe_q[MUX_LATENCY-1];

`ifdef ADPCM_B_REQUESTER_CHECK_EN
    logic proto_error_q, proto_error_d;

    always_comb begin
        proto_error_d = proto_error_q;
        if ((ym_io_en && in_a) || (ym_io_en && !mux_oe_n) || (pcm_load && !in_b)) begin
            proto_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) proto_error_q <= 1'b0;
        else       proto_error_q <= proto_error_d;
    end

    assign proto_error = proto_error_q;
`else
    assign proto_error = 1'b0;
`endif

endmodule

// File: tb/tb_adpcm_b_requester.sv
// Self-checking bench for adpcm_b_requester (default build, checker macro undefined).
module tb_adpcm_b_requester;

    localparam int H   = 4;
    localparam int LAT = 2;
    localparam int T   = 64;

    logic        clk, reset;
    logic        req_valid;
    logic [23:0] req_addr;
    logic        req_ready, pmpx, pmpx_rose, pmpx_fell;
    logic [2:0]  mux_sel;
    logic        mux_oe_n;
    logic [3:0]  ym_io, pcm_nybble;
    logic        ym_io_en, pcm_load;
    logic        rsp_valid, rsp_timeout, busy, proto_error;
    logic [7:0]  rsp_data;

    adpcm_b_requester #(
        .PMPX_HIGH_CYCLES(H),
        .MUX_LATENCY     (LAT),
        .TIMEOUT_CYCLES  (T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .pmpx       (pmpx),
        .pmpx_rose  (pmpx_rose),
        .pmpx_fell  (pmpx_fell),
        .mux_sel    (mux_sel),
        .mux_oe_n   (mux_oe_n),
        .ym_io      (ym_io),
        .pcm_nybble (pcm_nybble),
        .ym_io_en   (ym_io_en),
        .pcm_load   (pcm_load),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .proto_error(proto_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passes = 0;
    int fails = 0;
    int hist[$];  // lanes presented over the last LAT cycles, oldest first

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_lane(input logic [23:0] a, input bit phase_b,
                                    input logic [2:0] sel, input logic oe_n);
        int base;
        base = phase_b ? 3 : 0;
        if (oe_n) return 0;
        case (sel)
            3'b010:  return int'((a >> (4 * base)) & 24'hf);
            3'b110:  return int'((a >> (4 * (base + 1))) & 24'hf);
            3'b011:  return int'((a >> (4 * (base + 2))) & 24'hf);
            default: return 0;
        endcase
    endfunction

    task automatic push_lane(input int l);
        hist.push_back(l);
        void'(hist.pop_front());
    endtask

    task automatic clear_hist();
        hist.delete();
        for (int i = 0; i < LAT; i++) hist.push_back(0);
    endtask

    // One idle cycle: called at a falling edge, returns at the next one.
    task automatic idle_cycle();
        chk("idle_ready", req_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_pmpx", pmpx, 0);
        chk("idle_ym_io", ym_io, hist[0]);
        chk("idle_proto_error", proto_error, 0);
        req_valid = 1'b0;
        mux_sel   = 3'($urandom);
        mux_oe_n  = 1'($urandom);
        ym_io_en  = 1'($urandom);
        pcm_load  = 1'($urandom);
        push_lane(0);
        @(negedge clk);
    endtask

    task automatic run_request(input logic [23:0] addr, input int load_at, input bit directed);
        int done_at = -1;
        logic [3:0] lo = 4'd0, hi = 4'd0;
        bit tmo = 0;
        bit seen_resp = 0;
        chk("pre_ready", req_ready, 1);
        chk("pre_ym_io", ym_io, hist[0]);
        req_valid = 1'b1;
        req_addr  = addr;
        mux_sel   = 3'($urandom);
        mux_oe_n  = 1'($urandom);
        ym_io_en  = 1'b0;
        pcm_load  = 1'b0;
        push_lane(0);
        @(negedge clk);
        for (int k = 0; k < 200; k++) begin
            bit in_a, in_b, in_resp;
            in_a    = (k < H);
            in_b    = (k >= H) && (done_at < 0);
            in_resp = (done_at >= 0) && (k == done_at + 1);
            chk("pmpx", pmpx, in_a);
            chk("pmpx_rose", pmpx_rose, k == 0);
            chk("pmpx_fell", pmpx_fell, k == H);
            chk("busy", busy, in_a || in_b || in_resp);
            chk("req_ready", req_ready, !(in_a || in_b || in_resp));
            chk("rsp_valid", rsp_valid, in_resp);
            chk("ym_io", ym_io, hist[0]);
            if (in_resp) begin
                seen_resp = 1;
                chk("rsp_data", rsp_data, tmo ? 8'h00 : {hi, lo});
                chk("rsp_timeout", rsp_timeout, tmo);
                if (directed) chk("dir_rsp_data", rsp_data, 8'hA5);
            end
            if (directed && k == 2) chk("dir_lane_a0", ym_io, 4'h6);
            if (directed && k == H + 2) chk("dir_lane_b0", ym_io, 4'h3);
            if (done_at >= 0 && k == done_at + 3) break;

            mux_sel    = 3'($urandom);
            mux_oe_n   = 1'($urandom);
            pcm_nybble = 4'($urandom);
            req_valid  = (in_a || in_b) ? 1'($urandom) : 1'b0;
            req_addr   = 24'($urandom);
            if (directed) begin
                mux_oe_n = 1'b0;
                if (k == 0 || k == H)     mux_sel = 3'b010;
                if (k == 1 || k == H + 1) mux_sel = 3'b110;
                if (k == 2 || k == H + 2) mux_sel = 3'b011;
            end
            if (in_a) begin
                ym_io_en = 1'($urandom);
                pcm_load = 1'($urandom);
            end else if (in_b && k == load_at) begin
                ym_io_en = 1'b1;
                pcm_load = 1'b1;
                if (directed) pcm_nybble = 4'hA;
            end else if (in_b && k == load_at - 1) begin
                ym_io_en = 1'b1;
                pcm_load = 1'b0;
                mux_sel  = 3'b101;
                if (directed) pcm_nybble = 4'h5;
            end else if (in_b) begin
                ym_io_en = 1'($urandom);
                pcm_load = ym_io_en ? 1'b0 : 1'($urandom);
            end else begin
                ym_io_en = 1'($urandom);
                pcm_load = 1'($urandom);
            end

            if (in_b) begin
                if (ym_io_en && mux_sel == 3'b101) lo = pcm_nybble;
                if (ym_io_en && pcm_load) begin
                    hi = pcm_nybble;
                    done_at = k;
                end else if (k == T - 1) begin
                    done_at = k;
                    tmo = 1;
                end
            end
            push_lane((in_a || in_b) ? ref_lane(addr, in_b, mux_sel, mux_oe_n) : 0);
            @(negedge clk);
        end
        chk("resp_seen", seen_resp, 1);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_addr = 24'd0;
        mux_sel = 3'd0;
        mux_oe_n = 1'b1;
        pcm_nybble = 4'd0;
        ym_io_en = 1'b0;
        pcm_load = 1'b0;
        clear_hist();
        @(negedge clk);
        @(negedge clk);
        chk("rst_pmpx", pmpx, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_ym_io", ym_io, 0);
        chk("rst_proto_error", proto_error, 0);
        reset = 1'b0;
        idle_cycle();
        idle_cycle();

        run_request(24'h123456, H + 6, 1);
        idle_cycle();
        for (int i = 0; i < 6; i++) begin
            run_request(24'($urandom), H + 1 + int'($urandom_range(0, 30)), 0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        run_request(24'($urandom), 1000, 0);      // never loads: timeout
        run_request(24'($urandom), T - 1, 0);     // load coincides with timeout expiry

        // Abort in PHASE_B by asynchronous reset.
        req_valid = 1'b1;
        req_addr  = 24'h654321;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < H + 2; k++) @(negedge clk);
        chk("abort_in_b_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_pmpx", pmpx, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_ym_io", ym_io, 0);
        @(negedge clk);
        reset = 1'b0;
        clear_hist();
        for (int k = 0; k < 4; k++) idle_cycle();
        run_request(24'h123456, H + 6, 1);
        idle_cycle();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
